// File: rtl/md_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3 encodings, FSM states,
// iteration count and operand-signedness helpers.
package md_pkg;

   localparam int MD_ITERS = 32;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } md_state_e;

   // MUL is sign-agnostic in its low word, so it is treated as unsigned.
   function automatic logic op_a_signed(md_op_e o);
      return o inside {MULH, MULHSU, DIV, REM};
   endfunction

   function automatic logic op_b_signed(md_op_e o);
      return o inside {MULH, DIV, REM};
   endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps on
// unsigned magnitudes, then a one-cycle sign fix, for a fixed 34-cycle latency.
module mul_div_unit
   import md_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [ADDR_WIDTH-1:0] tag_in,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic [ADDR_WIDTH-1:0] tag_out
);

   localparam int DW = DATA_WIDTH;

   md_state_e             state_q, state_d;
   logic [5:0]            cnt_q, cnt_d;
   md_op_e                op_q, op_d;
   logic [ADDR_WIDTH-1:0] tag_q, tag_d;
   logic                  neg_a_q, neg_a_d;
   logic                  neg_b_q, neg_b_d;
   logic [2*DW-1:0]       acc_q, acc_d;
   logic [DW-1:0]         bmag_q, bmag_d;
   logic [DW-1:0]         result_q, result_d;
   logic [ADDR_WIDTH-1:0] tag_out_q, tag_out_d;
   logic                  done_q, done_d;

   // Multiply step: {hi, lo} holds partial product over the remaining multiplier bits.
   logic [DW:0]     mul_sum;
   logic [2*DW-1:0] mul_step;
   assign mul_sum  = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
   assign mul_step = {mul_sum, acc_q[DW-1:1]};

   // Divide step: {rem, quotient}; shifted remainder can briefly need DW+1 bits.
   logic [DW:0]     rem_sh;
   logic [DW-1:0]   rem_sub;
   logic [2*DW-1:0] div_step;
   assign rem_sh   = acc_q[2*DW-1:DW-1];
   assign rem_sub  = rem_sh[DW-1:0] - bmag_q;
   assign div_step = (rem_sh >= {1'b0, bmag_q}) ? {rem_sub, acc_q[DW-2:0], 1'b1}
                                                : {acc_q[2*DW-2:0], 1'b0};

   logic            sign_diff, b_zero;
   logic [2*DW-1:0] prod_fix;
   logic [DW-1:0]   quot_fix, rem_fix, fix_val;
   assign sign_diff = neg_a_q ^ neg_b_q;
   assign b_zero    = (bmag_q == '0);
   assign prod_fix  = sign_diff ? -acc_q : acc_q;
   assign quot_fix  = sign_diff ? -acc_q[DW-1:0] : acc_q[DW-1:0];
   assign rem_fix   = neg_a_q ? -acc_q[2*DW-1:DW] : acc_q[2*DW-1:DW];

   // Divide-by-zero: REM/REMU already yield a on the normal path; DIV needs the override.
   always_comb begin
      unique case (op_q)
         MUL:                fix_val = prod_fix[DW-1:0];
         MULH, MULHSU, MULHU: fix_val = prod_fix[2*DW-1:DW];
         DIV, DIVU:          fix_val = b_zero ? '1 : quot_fix;
         default:            fix_val = rem_fix;
      endcase
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      tag_d     = tag_q;
      neg_a_d   = neg_a_q;
      neg_b_d   = neg_b_q;
      acc_d     = acc_q;
      bmag_d    = bmag_q;
      result_d  = result_q;
      tag_out_d = tag_out_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = md_op_e'(op);
               tag_d   = tag_in;
               neg_a_d = op_a_signed(md_op_e'(op)) & a[DW-1];
               neg_b_d = op_b_signed(md_op_e'(op)) & b[DW-1];
               acc_d   = {{DW{1'b0}}, (neg_a_d ? -a : a)};
               bmag_d  = neg_b_d ? -b : b;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d = op_q[2] ? div_step : mul_step;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(MD_ITERS - 1)) state_d = FIX;
         end
         FIX: begin
            result_d  = fix_val;
            tag_out_d = tag_q;
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         result_q  <= '0;
         tag_out_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         tag_out_q <= tag_out_d;
         done_q    <= done_d;
      end
   end

   // NOTE: datapath registers are left unreset; they are always loaded on accept before use.
   always_ff @(posedge clk) begin
      op_q    <= op_d;
      tag_q   <= tag_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      acc_q   <= acc_d;
      bmag_q  <= bmag_d;
   end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign result  = result_q;
   assign tag_out = tag_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected result/tag/done-cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_mul_div_unit;

   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
   localparam int LAT = 34;

   logic        clk, rst, start, busy, done;
   logic [2:0]  op;
   logic [31:0] a, b, result;
   logic [4:0]  tag_in, tag_out;

   mul_div_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .tag_in(tag_in),
      .busy(busy), .done(done), .result(result), .tag_out(tag_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference model: RV32M semantics from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
      longint          sx, sy;
      longint unsigned ux, uy;
      logic [63:0]     p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      case (o)
         OP_MUL:    begin p = ux * uy;           return p[31:0];  end
         OP_MULH:   begin p = sx * sy;           return p[63:32]; end
         OP_MULHSU: begin p = sx * longint'(uy); return p[63:32]; end
         OP_MULHU:  begin p = ux * uy;           return p[63:32]; end
         OP_DIV:    begin if (y == 0) return '1; p = sx / sy; return p[31:0]; end
         OP_DIVU:   begin if (y == 0) return '1; p = ux / uy; return p[31:0]; end
         OP_REM:    begin if (y == 0) return x;  p = sx % sy; return p[31:0]; end
         default:   begin if (y == 0) return x;  p = ux % uy; return p[31:0]; end
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (sb_q.size() == 0) begin
            check("spurious_done", 1'b1, 1'b0);
         end else begin
            e = sb_q.pop_front();
            check("result", result, e.res);
            check("tag_out", tag_out, e.tag);
            check("done_cycle", cyc, e.cyc);
         end
      end
   end

   // Waits for idle, applies one op, then scrambles the inputs while the op runs.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] t, input logic [31:0] exp_res, input bit track);
      int guard = 0;
      exp_t e;
      @(negedge clk);
      while (busy && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (busy) check("idle_timeout", busy, 1'b0);
      start  = 1'b1;
      op     = o;
      a      = x;
      b      = y;
      tag_in = t;
      if (track) begin
         e.res = exp_res;
         e.tag = t;
         e.cyc = cyc + LAT;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      start  = 1'b0;
      op     = 3'($urandom);
      a      = $urandom;
      b      = $urandom;
      tag_in = 5'($urandom);
   endtask

   task automatic drain();
      int guard = 0;
      while (sb_q.size() != 0 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      check("drain", sb_q.size(), 0);
   endtask

   initial begin
      logic [2:0]  o;
      logic [31:0] x, y, ev;
      exp_t        e;
      rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; tag_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_result", result, 32'd0);
      check("rst_tag_out", tag_out, 5'd0);
      rst = 1'b1;

      issue(OP_MUL,    32'd7,          32'd6,          5'd5,  32'd42,         1'b1);
      issue(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd9,  32'hFFFF_FFFE,  1'b1);
      issue(OP_MULH,   -32'sd2,        32'd3,          5'd1,  32'hFFFF_FFFF,  1'b1);
      issue(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFF,  1'b1);
      issue(OP_DIV,    -32'sd7,        32'd2,          5'd3,  32'hFFFF_FFFD,  1'b1);
      issue(OP_REM,    -32'sd7,        32'd2,          5'd4,  32'hFFFF_FFFF,  1'b1);
      issue(OP_DIV,    32'd5,          32'd0,          5'd6,  32'hFFFF_FFFF,  1'b1);
      issue(OP_REMU,   32'h1234,       32'd0,          5'd7,  32'h1234,       1'b1);
      issue(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h8000_0000,  1'b1);
      issue(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd31, 32'd0,          1'b1);
      drain();

      // start held high: accepts land exactly LAT cycles apart
      @(negedge clk);
      o = 3'($urandom); x = $urandom; y = $urandom;
      ev = ref_model(o, x, y);
      for (int k = 1; k <= 3; k++) begin
         e.res = ev; e.tag = 5'd17; e.cyc = cyc + k * LAT;
         sb_q.push_back(e);
      end
      start = 1'b1; op = o; a = x; b = y; tag_in = 5'd17;
      repeat (2 * LAT + 1) @(posedge clk);
      #1 start = 1'b0;
      drain();

      // reset in cycle 15 of a DIVU aborts it with no done pulse
      issue(OP_DIVU, $urandom, $urandom | 32'd1, 5'd12, 32'd0, 1'b0);
      repeat (14) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_result", result, 32'd0);
      check("abort_tag_out", tag_out, 5'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2 * LAT) @(negedge clk);
      issue(OP_DIVU, 32'd100, 32'd7, 5'd14, 32'd14, 1'b1);

      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom);
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0:       y = 32'd0;
            1:       begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            2:       begin x = $urandom_range(0, 50); y = $urandom_range(1, 9); end
            3:       y = {28'hFFFF_FFF, 4'($urandom)};
            default: ;
         endcase
         issue(o, x, y, 5'($urandom), ref_model(o, x, y), 1'b1);
      end
      drain();
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
